// File: rtl/nibble_spi_tx_if.sv
// Word handshake and nibble-bus bundle for nibble_spi_tx.
// master = host/word source side, slave = the transmitter.
interface nibble_spi_tx_if #(
  parameter int REGSIZE = 32
);
  logic [REGSIZE-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [3:0]         nib_out;
  logic [1:0]         sel_out;
  logic               write_select;
  logic               busy;
  logic               done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, nib_out, sel_out, write_select, busy, done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, nib_out, sel_out, write_select, busy, done
  );
endinterface

// File: rtl/nibble_spi_tx.sv
// Serialises one REGSIZE-bit word as nibbles (setup cycle, then strobe cycle per nibble).
// Define NIBBLE_TX_LSB_FIRST_EN to send the least significant nibble first.
module nibble_spi_tx #(
  parameter int   REGSIZE    = 32,
  parameter logic SELECTCODE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  nibble_spi_tx_if.slave     bus
);
  localparam int N  = REGSIZE / 4;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]         state, state_n;
  logic [REGSIZE-1:0] shreg, shreg_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               accept, in_frame;
  logic [3:0]         nib_n;

  logic               tx_ready_q, busy_q, done_q, wsel_q;
  logic [3:0]         nib_q;
  logic [1:0]         sel_q;

  assign accept = bus.tx_valid & tx_ready_q;

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    case (state)
      S_IDLE: if (accept) begin
        shreg_n = bus.tx_data;
        cnt_n   = CW'(N);
        state_n = S_SETUP;
      end
      S_SETUP: state_n = S_STROBE;
      S_STROBE: begin
`ifdef NIBBLE_TX_LSB_FIRST_EN
        shreg_n = shreg >> 4;
`else
        shreg_n = shreg << 4;
`endif
        cnt_n   = cnt - CW'(1);
        state_n = (cnt == CW'(1)) ? S_DONE : S_SETUP;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  assign in_frame = (state_n == S_SETUP) || (state_n == S_STROBE);
`ifdef NIBBLE_TX_LSB_FIRST_EN
  assign nib_n = shreg_n[3:0];
`else
  assign nib_n = shreg_n[REGSIZE-1 -: 4];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      cnt        <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nib_q      <= 4'h0;
      sel_q      <= 2'b00;
      wsel_q     <= SELECTCODE;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      tx_ready_q <= (state_n == S_IDLE);
      busy_q     <= (state_n != S_IDLE);
      done_q     <= (state_n == S_DONE);
      nib_q      <= in_frame ? nib_n : 4'h0;
      // Count still equals N through both cycles of the first nibble.
      sel_q[1]   <= in_frame && (cnt_n == CW'(N));
      sel_q[0]   <= (state_n == S_STROBE);
      wsel_q     <= SELECTCODE;
    end
  end

  assign bus.tx_ready     = tx_ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.nib_out      = nib_q;
  assign bus.sel_out      = sel_q;
  assign bus.write_select = wsel_q;
endmodule

// File: tb/tb_nibble_spi_tx.sv
// Bench for nibble_spi_tx: a 32-bit/select-0 and a 128-bit/select-1 instance against a frame-timing model.
module tb_nibble_spi_tx;
  localparam int NA = 8;
  localparam int NB = 32;

`ifdef NIBBLE_TX_LSB_FIRST_EN
  localparam logic [31:0]  EXP_A   = 32'h87654321;
  localparam logic [31:0]  EXP_R   = 32'h5A5A5A5A;
  localparam logic [127:0] EXP_B   = 128'hFEDCBA9876543210FEDCBA9876543210;
  localparam logic [3:0]   FIRST_A = 4'h8;
  localparam logic [3:0]   LAST_B  = 4'h0;
`else
  localparam logic [31:0]  EXP_A   = 32'h12345678;
  localparam logic [31:0]  EXP_R   = 32'hA5A5A5A5;
  localparam logic [127:0] EXP_B   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [3:0]   FIRST_A = 4'h1;
  localparam logic [3:0]   LAST_B  = 4'hF;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nibble_spi_tx_if #(.REGSIZE(32))  ia();
  nibble_spi_tx_if #(.REGSIZE(128)) ib();

  nibble_spi_tx #(.REGSIZE(32),  .SELECTCODE(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  nibble_spi_tx #(.REGSIZE(128), .SELECTCODE(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  int errors = 0;
  int checks = 0;

  // Model: remember the edge index of each accept; cycle c = edges since accept.
  int             ecount = 0;
  int             sa = 0, sb = 0;
  bit             aa = 1'b0, ab = 1'b0;
  logic [127:0]   wa = '0, wb = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aa <= 1'b0;
      ab <= 1'b0;
    end else begin
      ecount <= ecount + 1;
      if (ia.tx_valid && (!aa || (ecount - sa) >= 2*NA+2)) begin
        aa <= 1'b1; sa <= ecount; wa <= 128'(ia.tx_data);
      end
      if (ib.tx_valid && (!ab || (ecount - sb) >= 2*NB+2)) begin
        ab <= 1'b1; sb <= ecount; wb <= ib.tx_data;
      end
    end
  end

  // {ready, busy, done, write_select, sel_out[1], sel_out[0], nib_out[3:0]}
  function automatic logic [9:0] expect_out(bit act, int c, logic [127:0] w, int n, logic sc);
    int k;
    logic [3:0] nib;
    if (!act || c >= 2*n+2) return {1'b1, 1'b0, 1'b0, sc, 2'b00, 4'h0};
    if (c == 2*n+1)         return {1'b0, 1'b1, 1'b1, sc, 2'b00, 4'h0};
    k = (c - 1) / 2;
`ifdef NIBBLE_TX_LSB_FIRST_EN
    nib = w[4*k +: 4];
`else
    nib = w[4*(n-1-k) +: 4];
`endif
    return {1'b0, 1'b1, 1'b0, sc, (k == 0), (c % 2 == 0), nib};
  endfunction

  task automatic compare();
    logic [9:0] ea, eb, xa, xb;
    ea = expect_out(aa, ecount - sa, wa, NA, 1'b0);
    eb = expect_out(ab, ecount - sb, wb, NB, 1'b1);
    xa = {ia.tx_ready, ia.busy, ia.done, ia.write_select, ia.sel_out, ia.nib_out};
    xb = {ib.tx_ready, ib.busy, ib.done, ib.write_select, ib.sel_out, ib.nib_out};
    checks += 2;
    if (xa !== ea) begin
      errors++;
      $display("FAIL cycle_a t=%0t got=%b want=%b (rdy,busy,done,ws,sel,nib)", $time, xa, ea);
    end
    if (xb !== eb) begin
      errors++;
      $display("FAIL cycle_b t=%0t got=%b want=%b (rdy,busy,done,ws,sel,nib)", $time, xb, eb);
    end
  endtask

  task automatic chk(string name, logic [127:0] got, logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  logic [31:0]  acc_a, acc_r;
  logic [127:0] acc_b;
  logic [31:0]  fmask;
  logic [3:0]   first_a, nib20, last_b;
  logic [1:0]   sel20;
  int           ns_a, ns_b, ns_r, done_a, rdy_a, done_b;
  bit           got_rdy;

  initial begin
    rst_n = 1'b0;
    ia.tx_valid = 1'b0; ia.tx_data = '0;
    ib.tx_valid = 1'b0; ib.tx_data = '0;
    repeat (3) step();
    chk("rst_ready", 128'(ia.tx_ready), 128'(1));
    chk("rst_sel",   128'(ia.sel_out),  128'(0));
    chk("rst_ws_b",  128'(ib.write_select), 128'(1));
    rst_n = 1'b1;
    step();

    // Word A held valid with data changing mid-frame; word B is a one-cycle pulse.
    ia.tx_data = 32'h12345678; ia.tx_valid = 1'b1;
    ib.tx_data = 128'h0123456789ABCDEF0123456789ABCDEF; ib.tx_valid = 1'b1;
    acc_a = '0; acc_b = '0; fmask = '0; ns_a = 0; ns_b = 0;
    done_a = -1; rdy_a = -1; done_b = -1;
    first_a = 4'h0; nib20 = 4'h0; sel20 = 2'b00; last_b = 4'h0;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (c == 1) begin ib.tx_valid = 1'b0; first_a = ia.nib_out; end
      if (c == 3) ia.tx_data = 32'hFFFFFFFF;
      if (c == 19) ia.tx_valid = 1'b0;
      if (c <= 17) begin
        if (ia.sel_out[0]) begin acc_a = {acc_a[27:0], ia.nib_out}; ns_a++; end
        if (ia.sel_out[1]) fmask[c] = 1'b1;
      end
      if (ia.done && done_a < 0) done_a = c;
      if (ia.tx_ready && rdy_a < 0) rdy_a = c;
      if (c == 20) begin sel20 = ia.sel_out; nib20 = ia.nib_out; end
      if (ib.sel_out[0]) begin acc_b = {acc_b[123:0], ib.nib_out}; ns_b++; last_b = ib.nib_out; end
      if (ib.done && done_b < 0) done_b = c;
    end
    chk("a_nibbles",    128'(acc_a),   128'(EXP_A));
    chk("a_strobes",    128'(ns_a),    128'(8));
    chk("a_first_nib",  128'(first_a), 128'(FIRST_A));
    chk("a_frame_mask", 128'(fmask),   128'(32'h6));
    chk("a_done_cyc",   128'(done_a),  128'(17));
    chk("a_ready_cyc",  128'(rdy_a),   128'(18));
    chk("a2_sel_c20",   128'(sel20),   128'(2'b11));
    chk("a2_nib_c20",   128'(nib20),   128'(4'hF));
    chk("b_nibbles",    acc_b,         EXP_B);
    chk("b_strobes",    128'(ns_b),    128'(32));
    chk("b_done_cyc",   128'(done_b),  128'(65));
    chk("b_last_nib",   128'(last_b),  128'(LAST_B));

    // Mid-frame asynchronous reset, then a frame on the first edge after release.
    got_rdy = 1'b0;
    for (int i = 0; i < 100 && !got_rdy; i++) begin
      if (ia.tx_ready) got_rdy = 1'b1;
      else step();
    end
    chk("wait_ready", 128'(got_rdy), 128'(1));
    ia.tx_data = 32'h12345678; ia.tx_valid = 1'b1;
    step();
    ia.tx_valid = 1'b0;
    repeat (6) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_sel",   128'(ia.sel_out),  128'(0));
    chk("mrst_nib",   128'(ia.nib_out),  128'(0));
    chk("mrst_busy",  128'(ia.busy),     128'(0));
    chk("mrst_ready", 128'(ia.tx_ready), 128'(1));
    step();
    rst_n = 1'b1;
    ia.tx_data = 32'hA5A5A5A5; ia.tx_valid = 1'b1;
    step();
    ia.tx_valid = 1'b0;
    acc_r = '0; ns_r = 0;
    for (int c = 2; c <= 20; c++) begin
      step();
      if (ia.sel_out[0]) begin acc_r = {acc_r[27:0], ia.nib_out}; ns_r++; end
    end
    chk("r_nibbles", 128'(acc_r), 128'(EXP_R));
    chk("r_strobes", 128'(ns_r),  128'(8));

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      ia.tx_valid = ($urandom_range(0, 3) == 0);
      ia.tx_data  = $urandom;
      ib.tx_valid = ($urandom_range(0, 3) == 0);
      ib.tx_data  = {$urandom, $urandom, $urandom, $urandom};
      rst_n       = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_n = 1'b1;
    ia.tx_valid = 1'b0; ib.tx_valid = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_spi_tx.md
Name: nibble_spi_tx

Overview:
- Host-side transmitter for the 4-bit nibble load interface used by the weight/data shadow-register receivers.
- Accepts one REGSIZE-bit word over a valid/ready handshake and serialises it as nibbles, with a frame flag, a per-nibble strobe and a constant register-select bit.
- Used in the bring-up/test harness and the FPGA wrapper to preload weights and data into the convolution core.

Parameters:
- REGSIZE, 32, word width in bits; must be a multiple of 4 and at least 8. N = REGSIZE/4 nibbles per word.
- SELECTCODE, 1'b0, value driven on write_select; selects the target receiver (0 = weights, 1 = data).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  REGSIZE  word to send; sampled only on accept.
- tx_valid  input  1  word available.
- tx_ready  output  1  high only in IDLE; accept = tx_valid & tx_ready at a rising edge.
- nib_out  output  4  nibble bus (receiver I).
- sel_out  output  2  [0] = nibble strobe, [1] = frame-start flag (receiver S).
- write_select  output  1  receiver select.
- busy  output  1  high in SETUP, STROBE and DONE.
- done  output  1  one-cycle pulse after the last nibble.

Behaviour:
- All outputs are registered.
- Reset values: tx_ready=1, nib_out=0, sel_out=2'b00, busy=0, done=0, write_select=SELECTCODE. Shift register and nibble counter clear to 0.
- FSM states:
  - IDLE: waits for accept.
  - SETUP: presents the current nibble; strobe is low.
  - STROBE: same nibble; sel_out[0]=1.
  - DONE: one cycle, then back to IDLE.
- On accept in IDLE: capture tx_data into the shift register, load count=N, go to SETUP.
- SETUP -> STROBE unconditionally.
- STROBE: shift left by 4 and decrement count. If count reaches 0, go to DONE; otherwise go to SETUP.
- Nibble order is MSB first: nib_out = shreg[REGSIZE-1:REGSIZE-4].
- nib_out is stable across each SETUP+STROBE pair. This gives one cycle of setup before the strobe.
- sel_out[1]=1 only during the SETUP and STROBE cycles of the first nibble; 0 otherwise.
- IDLE and DONE: nib_out=0, sel_out=0.
- done=1 exactly in the DONE cycle.
- Timing, with accept at edge E0 defined as cycle 0:
  - k-th strobe (k = 0..N-1) falls in cycle 2k+2.
  - done in cycle 2N+1.
  - tx_ready returns in cycle 2N+2.
  - Minimum accept-to-accept spacing is 2N+2 cycles.
- tx_valid while busy is ignored. Changes to tx_data after accept have no effect.
- write_select is SELECTCODE at all times.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronous). No partial-frame completion. A new frame may be accepted on the first edge after rst_n deasserts.
- Counter width: clog2(N+1) bits. No wrap: count is only decremented in STROBE, when it is at least 1.

Optional Feature:
- Macro: NIBBLE_TX_LSB_FIRST_EN.
- Defined: nibbles are sent LSB first (shift right, nib_out = shreg[3:0]). sel_out[1] still flags the first transmitted nibble. Timing is identical.
- Undefined: MSB-first order as above.

Test Plan:
- REGSIZE=32, accept tx_data=32'h12345678 at cycle 0:
  - nib_out = 1,2,3,4,5,6,7,8, with sel_out[0]=1 in cycles 2,4,…,16.
  - sel_out[1]=1 in cycles 1–2 only.
  - done=1 in cycle 17 only; tx_ready=1 from cycle 18.
- Hold tx_valid=1 continuously, changing tx_data to 32'hFFFFFFFF in cycle 3:
  - the first frame still sends 1..8.
  - the second word (FFFFFFFF) is accepted at cycle 18, and its first strobe is in cycle 20.
- Assert rst_n=0 in cycle 7 (mid-nibble 3):
  - sel_out=0, nib_out=0, busy=0 and tx_ready=1 before the next edge.
  - after release, accepting 32'hA5A5A5A5 sends A,5,A,5,A,5,A,5.
- REGSIZE=128, SELECTCODE=1, data = 128'h0123…CDEF repeated:
  - 32 strobes; done in cycle 65; write_select=1 throughout.
  - the last nibble is F.
- NIBBLE_TX_LSB_FIRST_EN defined, 32'h12345678:
  - nibbles 8,7,6,5,4,3,2,1.
  - sel_out[1] is high with nibble 8.
- Single-cycle tx_valid pulse in cycle 0 with tx_ready=1: accepted, and the frame completes normally.
